// File: rtl/bpa_pkg.sv
// bpa_pkg: nibble-level types and constants shared across the butterfly multiplier datapath.
package bpa_pkg;
    localparam int NIB_W = 4;
    typedef logic [NIB_W-1:0] nibble_t;
endpackage

// File: rtl/butterfly_cla4_slice.sv
// butterfly_cla4_slice: combinational 4-bit carry-lookahead adder slice.
import bpa_pkg::*;
module butterfly_cla4_slice (
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             ci,
    output logic [NIB_W-1:0] s,
    output logic             co
);
    nibble_t w_g, w_p, w_c;
    assign w_g = a & b;
    assign w_p = a | b;
    assign w_c[0] = ci;
    assign w_c[1] = w_g[0] | (w_p[0] & ci);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & ci);
    assign co = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0]) | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);
    assign s = a ^ b ^ w_c;
endmodule

// File: rtl/butterfly_pipe_adder.sv
// butterfly_pipe_adder: nibble-per-stage pipelined CLA adder with valid/ready on both sides.
// Define BPA_OVF_EN to add the registered signed-overflow output ovf.
import bpa_pkg::*;
module butterfly_pipe_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef BPA_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int NSTG = WIDTH / NIB_W;
    logic [NSTG-1:0]  r_v, r_c;
    logic [WIDTH-1:0] r_pa [NSTG];
    logic [WIDTH-1:0] r_pb [NSTG];
    logic [WIDTH-1:0] r_s  [NSTG];
    logic [NSTG:0]    w_adv;
    logic [NSTG-1:0]  w_vi, w_ci, w_co;
    logic [WIDTH-1:0] w_pa [NSTG];
    logic [WIDTH-1:0] w_pb [NSTG];
    logic [WIDTH-1:0] w_si [NSTG];
    nibble_t          w_ns [NSTG];

    // Pending operands are kept right-aligned so every stage adds bits [3:0].
    always_comb begin
        w_adv[NSTG] = out_ready;
        for (int i = NSTG - 1; i >= 0; i--) w_adv[i] = !r_v[i] || w_adv[i+1];
        w_vi[0] = in_valid;
        w_ci[0] = c_in;
        w_pa[0] = a;
        w_pb[0] = b;
        w_si[0] = '0;
        for (int i = 1; i < NSTG; i++) begin
            w_vi[i] = r_v[i-1];
            w_ci[i] = r_c[i-1];
            w_pa[i] = r_pa[i-1];
            w_pb[i] = r_pb[i-1];
            w_si[i] = r_s[i-1];
        end
    end

    for (genvar k = 0; k < NSTG; k++) begin : g_cla
        butterfly_cla4_slice u_cla (
            .a  (w_pa[k][NIB_W-1:0]),
            .b  (w_pb[k][NIB_W-1:0]),
            .ci (w_ci[k]),
            .s  (w_ns[k]),
            .co (w_co[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= '0;
            r_c <= '0;
            for (int i = 0; i < NSTG; i++) begin
                r_pa[i] <= '0;
                r_pb[i] <= '0;
                r_s[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NSTG; i++) begin
                if (w_adv[i]) begin
                    r_v[i]  <= w_vi[i];
                    r_c[i]  <= w_co[i];
                    r_pa[i] <= w_pa[i] >> NIB_W;
                    r_pb[i] <= w_pb[i] >> NIB_W;
                    r_s[i]  <= w_si[i] | (WIDTH'(w_ns[i]) << (NIB_W * i));
                end
            end
        end
    end

`ifdef BPA_OVF_EN
    // The last stage's nibble operands still hold the original sign bits.
    logic r_ovf;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ovf <= 1'b0;
        else if (w_adv[NSTG-1])
            r_ovf <= (w_pa[NSTG-1][NIB_W-1] == w_pb[NSTG-1][NIB_W-1])
                  && (w_ns[NSTG-1][NIB_W-1] != w_pa[NSTG-1][NIB_W-1]);
    end
    assign ovf = r_ovf;
`endif

    assign in_ready  = w_adv[0];
    assign out_valid = r_v[NSTG-1];
    assign c_out     = r_c[NSTG-1];
    assign sum       = r_s[NSTG-1];
endmodule
